fft_core_arbiter: RTL

Shares one FFT engine between two requesters (e.g. two acquisition channels) with round-robin arbitration. It grants the engine to one requester and muxes that requester's sample buses into the engine. It pulses the engine start, waits for completion (rising edge of the engine ready), then holds results for the owner until the owner releases. A watchdog aborts a grant if the engine never completes.

---
 rtl/fft_core_arbiter_pkg.sv | 14 +
 rtl/fft_rr_pick_2.sv | 12 +
 rtl/fft_core_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fft_core_arbiter_pkg.sv
// Shared definitions for the two-requester FFT engine arbiter.
package fft_core_arbiter_pkg;

    localparam int NREQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/fft_rr_pick_2.sv
// Combinational 2-way round-robin picker: rr names the requester with first priority.
module fft_rr_pick_2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       valid,
    output logic       idx
);

    assign valid = |req;
    assign idx   = req[rr] ? rr : ~rr;

endmodule

// File: rtl/fft_core_arbiter.sv
// Round-robin owner of a single FFT engine: grant, start pulse, completion on
// ready rising edge, result hold until owner release, watchdog abort.
module fft_core_arbiter
    import fft_core_arbiter_pkg::*;
#(
    parameter int N           = 1024,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        done_i,
    input  logic [NREQ*DATA_W-1:0] rq_x0_re_i,
    input  logic [NREQ*DATA_W-1:0] rq_x0_im_i,
    input  logic [NREQ*DATA_W-1:0] rq_x1_re_i,
    input  logic [NREQ*DATA_W-1:0] rq_x1_im_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   busy_o,
    output logic [NREQ-1:0]        result_valid_o,
    output logic                   err_o,
    output logic                   err_id_o,
    output logic                   core_start_o,
    input  logic                   core_ready_i,
    output logic [DATA_W-1:0]      core_x0_re_o,
    output logic [DATA_W-1:0]      core_x0_im_o,
    output logic [DATA_W-1:0]      core_x1_re_o,
    output logic [DATA_W-1:0]      core_x1_im_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // N only documents the engine pairing; reject nonsense at elaboration.
    if (TIMEOUT_CYC < 2 || N < 2) begin : g_param_check
        $error("fft_core_arbiter: TIMEOUT_CYC and N must be >= 2");
    end

    state_t            state, state_n;
    logic              rr;
    logic              owner;
    logic [CNT_W-1:0]  cnt;
    logic              ready_q;
    logic              rise;
    logic              pick_vld;
    logic              pick_idx;
    logic [NREQ-1:0]   owner_oh;

    fft_rr_pick_2 u_pick (
        .req   (req_i),
        .rr    (rr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign rise     = core_ready_i & ~ready_q;
    assign owner_oh = owner ? 2'b10 : 2'b01;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (pick_vld) state_n = ST_START;
            ST_START: state_n = ST_BUSY;
            // Completion beats the watchdog when both land together.
            ST_BUSY: begin
                if (rise)                 state_n = ST_DONE;
                else if (cnt == CNT_LAST) state_n = ST_ERR;
            end
            ST_DONE:  if (done_i[owner]) state_n = ST_IDLE;
            ST_ERR:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            rr           <= 1'b0;
            owner        <= 1'b0;
            cnt          <= '0;
            ready_q      <= 1'b0;
            gnt_o        <= '0;
            core_start_o <= 1'b0;
            err_o        <= 1'b0;
            err_id_o     <= 1'b0;
        end else begin
            state        <= state_n;
            ready_q      <= core_ready_i;
            core_start_o <= (state == ST_START);
            err_o        <= (state_n == ST_ERR);

            if (state == ST_IDLE && pick_vld) begin
                owner <= pick_idx;
                gnt_o <= pick_idx ? 2'b10 : 2'b01;
            end

            if (state == ST_START)     cnt <= '0;
            else if (state == ST_BUSY) cnt <= cnt + 1'b1;

            if (state_n == ST_ERR) err_id_o <= owner;

            // Release or abort hands priority to the other requester.
            if ((state == ST_DONE || state == ST_ERR) && state_n == ST_IDLE) begin
                gnt_o <= '0;
                rr    <= ~owner;
            end
        end
    end

    assign busy_o         = (state != ST_IDLE);
    assign result_valid_o = (state == ST_DONE) ? owner_oh : '0;

    function automatic logic [DATA_W-1:0] mux_sel(input logic [NREQ*DATA_W-1:0] bus,
                                                  input logic [NREQ-1:0]        g);
        mux_sel = '0;
        for (int k = 0; k < NREQ; k++)
            if (g[k]) mux_sel = bus[k*DATA_W +: DATA_W];
    endfunction

    assign core_x0_re_o = mux_sel(rq_x0_re_i, gnt_o);
    assign core_x0_im_o = mux_sel(rq_x0_im_i, gnt_o);
    assign core_x1_re_o = mux_sel(rq_x1_re_i, gnt_o);
    assign core_x1_im_o = mux_sel(rq_x1_im_i, gnt_o);

endmodule
